decoder_select_sequencer: RTL and testbench

//  Upstream driver for the 2-to-4 decoder: arbitrates four request lines round-robin and

---
 rtl/decoder_select_sequencer_pkg.sv | 13 +
 rtl/decoder_select_sequencer_rr_pick4.sv | 29 ++
 rtl/decoder_select_sequencer.sv | 115 +++++++++++
 tb/tb_decoder_select_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/decoder_select_sequencer_pkg.sv
// Shared types and sizes for the decoder select sequencer.
package decoder_select_sequencer_pkg;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_select_sequencer_rr_pick4.sv
// Round-robin pick of four requests, scanning upward from the slot after the last winner.
module decoder_select_sequencer_rr_pick4
  import decoder_select_sequencer_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   winner
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // First set bit at last+1, last+2, ... (mod 4); lowest offset wins.
  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = last + SEL_W'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_select_sequencer.sv
// Round-robin driver for a 2-to-4 decoder: one grant at a time, bounded dwell,
// and a mandatory idle gap between consecutive grants.
module decoder_select_sequencer
  import decoder_select_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_MAX = 15,
  parameter int unsigned DWELL_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [SEL_W-1:0]   sel,
  output logic               enable,
  output logic               busy,
  output logic               timeout
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_MAX - 1);
  localparam logic [DWELL_W-1:0] DWELL_SAT  = '1;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_winner;
  logic               owner_req;
  logic               dwell_expired;

  decoder_select_sequencer_rr_pick4 u_pick (
    .req    (req),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  assign owner_req     = req[sel_q];
  assign dwell_expired = (dwell_q == DWELL_LAST);

  // Next-state, dwell and output-register computation.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    dwell_d   = dwell_q;
    enable_d  = 1'b0;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_d    = pick_winner;
          last_d   = pick_winner;
          dwell_d  = '0;
          enable_d = 1'b1;
          state_d  = ST_GRANT;
        end
      end

      ST_GRANT: begin
        enable_d = 1'b1;
        dwell_d  = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + DWELL_W'(1);
        if (done || !owner_req || dwell_expired) begin
          enable_d  = 1'b0;
          state_d   = ST_GAP;
          // Flag expiry only when it is the sole reason for the release.
          timeout_d = dwell_expired && !done && owner_req;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      last_q    <= '1;
      dwell_q   <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      dwell_q   <= dwell_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel     = sel_q;
  assign enable  = enable_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Directed bench for decoder_select_sequencer with hand-computed expectations.
module tb_decoder_select_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       enable;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  decoder_select_sequencer #(
    .DWELL_MAX (15),
    .DWELL_W   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .enable  (enable),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {sel, enable, busy, timeout} against the expected tuple.
  task automatic expect_out(input string tag, input logic [1:0] e_sel,
                            input logic e_en, input logic e_busy, input logic e_to);
    logic [4:0] obs_v;
    logic [4:0] exp_v;
    obs_v = {sel, enable, busy, timeout};
    exp_v = {e_sel, e_en, e_busy, e_to};
    checks++;
    assert (obs_v === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed sel/en/busy/to=%b required %b", tag, obs_v, exp_v);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'hF;
    done = 1'b0;

    // Reset held two edges with all requests high.
    tick();
    tick();
    expect_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'h0;
    tick();
    expect_out("idle_after_reset", 2'd0, 1'b0, 1'b0, 1'b0);

    // Single request on line 2, released by done after 3 enabled cycles.
    req = 4'b0100;
    tick();
    expect_out("single_grant", 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("single_en2", 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("single_en3", 2'd2, 1'b1, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("single_gap", 2'd2, 1'b0, 1'b1, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    expect_out("single_idle", 2'd2, 1'b0, 1'b0, 1'b0);

    // Round-robin from a fresh reset: order 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [1:0] exp_sel;
      exp_sel = 2'(g % 4);
      tick();
      expect_out("rr_grant", exp_sel, 1'b1, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      expect_out("rr_gap", exp_sel, 1'b0, 1'b1, 1'b0);
      done = 1'b0;
      tick();
      expect_out("rr_idle", exp_sel, 1'b0, 1'b0, 1'b0);
    end

    // Dwell expiry: line 1 held, no done -> 15 enabled cycles then timeout.
    req = 4'b0010;
    tick();
    expect_out("dwell_grant", 2'd1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 14; c++) begin
      tick();
      expect_out("dwell_hold", 2'd1, 1'b1, 1'b1, 1'b0);
    end
    tick();
    expect_out("dwell_timeout", 2'd1, 1'b0, 1'b1, 1'b1);
    tick();
    expect_out("dwell_idle", 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("dwell_regrant", 2'd1, 1'b1, 1'b1, 1'b0);

    // Request drop during grant releases without timeout.
    req = 4'b0000;
    tick();
    expect_out("reqdrop_gap", 2'd1, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("reqdrop_idle", 2'd1, 1'b0, 1'b0, 1'b0);

    // done coinciding with dwell expiry: one release, no timeout.
    req = 4'b0010;
    tick();
    expect_out("simul_grant", 2'd1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 14; c++) begin
      tick();
    end
    expect_out("simul_last_en", 2'd1, 1'b1, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("simul_release", 2'd1, 1'b0, 1'b1, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    expect_out("simul_idle", 2'd1, 1'b0, 1'b0, 1'b0);

    // Reset mid-grant on line 3, then 1001 must grant line 0 first.
    req = 4'b1000;
    tick();
    expect_out("mid_grant", 2'd3, 1'b1, 1'b1, 1'b0);
    tick();
    expect_out("mid_hold", 2'd3, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    req = 4'b1001;
    tick();
    expect_out("mid_reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("post_reset_grant", 2'd0, 1'b1, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("post_reset_gap", 2'd0, 1'b0, 1'b1, 1'b0);
    done = 1'b0;
    tick();
    expect_out("post_reset_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("post_reset_next", 2'd3, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
